// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU operation requests, issues them one at a
// time to a combinational 4-bit ALU and returns tagged 8-bit results.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_code,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_code,
  output logic             alu_en,
  input  logic [7:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_code,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [2:0]       code;
    logic             chain;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             release_res;
  logic [3:0]       last_nib;
  logic [TAG_W-1:0] iss_tag;
  state_t           state;
  state_t           state_nx;

  // Full is decoded from the registered count, so a same-cycle pop
  // never opens a slot for a push.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // Command storage; contents need no reset, the count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, code: cmd_code,
                       chain: cmd_chain, tag: cmd_tag};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: ISSUE is always one cycle, HOLD waits for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   state_nx = HOLD;
      HOLD: begin
        if (res_ready) state_nx = empty ? IDLE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-state strobes: pop a command, capture the ALU, retire a result.
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      ISSUE: capture = 1'b1;
      HOLD: begin
        release_res = res_ready;
        pop         = res_ready && !empty;
      end
      default: ;
    endcase
  end

  // ALU drive and result capture; alu_result is only sampled in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_code  <= '0;
      alu_en    <= 1'b0;
      iss_tag   <= '0;
      last_nib  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_code  <= '0;
      res_tag   <= '0;
      op_count  <= '0;
    end else begin
      if (release_res) res_valid <= 1'b0;
      if (pop) begin
        alu_a    <= head.chain ? last_nib : head.a;
        alu_b    <= head.b;
        alu_code <= head.code;
        alu_en   <= 1'b1;
        iss_tag  <= head.tag;
      end
      if (capture) begin
        res_data  <= alu_result;
        last_nib  <= alu_result[3:0];
        res_code  <= alu_code;
        res_tag   <= iss_tag;
        res_valid <= 1'b1;
        op_count  <= op_count + 8'd1;
        alu_en    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the team's 4-bit `alu` block. It accepts operation requests over a valid/ready stream and buffers them in a small FIFO. It drives the ALU's `a`, `b`, `code` and `en` inputs one operation at a time, captures the 8-bit `aluout`, and returns it with its tag on a valid/ready result stream. An optional chain mode feeds the previous result back as operand A.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, 2–16.
- `TAG_W`, default 4: width of the user tag carried from command to result.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_a`  in  4  operand A.
- `cmd_b`  in  4  operand B.
- `cmd_code`  in  3  ALU op code, 0–7, passed through unchanged.
- `cmd_chain`  in  1  1 = use low nibble of last captured result as A; ignore `cmd_a`.
- `cmd_tag`  in  TAG_W  user tag.
- `alu_a`  out  4  to ALU `a`; registered.
- `alu_b`  out  4  to ALU `b`; registered.
- `alu_code`  out  3  to ALU `code`; registered.
- `alu_en`  out  1  to ALU `en`; registered.
- `alu_result`  in  8  from ALU `aluout`.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_data`  out  8  captured ALU result.
- `res_code`  out  3  op code of that result.
- `res_tag`  out  TAG_W  tag of that result.
- `busy`  out  1  1 when state ≠ IDLE or FIFO not empty.
- `op_count`  out  8  number of results captured; wraps.

## Operation

- **FIFO**
  - Holds {a, b, code, chain, tag}.
  - `cmd_ready = !full && !rst`, where full is decoded from the registered count.
  - A push while full is impossible by construction. A pop in the same cycle does not free a slot for a push in that cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
- **FSM states:** IDLE, ISSUE, HOLD.
  - **IDLE.** `alu_en=0`. If the FIFO is not empty: pop the head and register its operands onto `alu_a`/`alu_b`/`alu_code`, set `alu_en=1`, go to ISSUE.
    - `alu_a` = `last_result[3:0]` if chain=1, else the stored a.
  - **ISSUE.** Lasts exactly one cycle; the ALU is combinational and settles within it.
    - At the closing edge: `res_data<=alu_result`, `last_result<=alu_result`, `res_code`/`res_tag` from the issued entry, `res_valid<=1`, `op_count<=op_count+1` (mod 256), `alu_en<=0`.
    - Go to HOLD.
  - **HOLD.** `res_valid=1`; `res_data`, `res_code` and `res_tag` stay stable until the handshake.
    - On `res_ready`: `res_valid<=0`.
    - If the FIFO is not empty, pop directly into ISSUE in the same edge (back-to-back); otherwise go to IDLE.
    - `res_valid` must never drop without a handshake.
- **Z guard.** `alu_result` is sampled only at the ISSUE edge. The ALU drives Z when `alu_en=0`, so sampling at any other time is forbidden.
- **Chain reads.** `last_result` resets to 0, so a chain command issued before any capture uses A=0. Chaining always reads the most recent capture, because operations are strictly serial.
- **Arithmetic.** None in this block. All results are the ALU's 8-bit output, including subtraction wrap (e.g. 0x0A−0x0B = 0xFF).

## Timing

- **Reset values:**
  - `alu_a=0`, `alu_b=0`, `alu_code=0`, `alu_en=0`
  - `res_valid=0`, `res_data=0`, `res_code=0`, `res_tag=0`
  - `op_count=0`, `busy=0`, `cmd_ready=0`
  - FIFO empty, state IDLE, `last_result=0`
- **Latency.** Command accepted at edge N into an empty FIFO in IDLE: ISSUE from edge N+1, `res_valid=1` after edge N+2.
- **Throughput.** With `res_ready` held high and the FIFO non-empty, one result every 2 cycles (ISSUE, HOLD, ISSUE, …).
- **Capacity under backpressure.** `FIFO_DEPTH+1` commands are accepted: one sits in HOLD, `FIFO_DEPTH` wait in the FIFO.
- **Reset mid-operation.** All state clears immediately. `alu_en` and `res_valid` drop asynchronously; pending commands are discarded.

## Test plan

Bench instantiates `alu_cmd_sequencer` with `alu`.

1. **Op sweep.** Codes 0–7 with a=0xA, b=0xB, `res_ready=1`.
   - Expect `res_data` 0x15, 0xFF, 0xF5, 0x6E, 0x0A, 0x0B, 0xF5, 0xF4, in order.
   - Expect tags echoed and results spaced 2 cycles apart.
2. **Latency.** A single command accepted at edge N.
   - `res_valid` rises after edge N+2.
   - `alu_en` is high for exactly one cycle.
3. **Chain.** Add 3+4, then chain add with b=2, then chain multiply with b=3.
   - Results 0x07, 0x09, 0x1B.
4. **Backpressure.** `res_ready=0`, `cmd_valid` held.
   - Exactly 5 commands accepted, then `cmd_ready=0`.
   - `res_data` is held stable.
   - After releasing `res_ready`, all 5 results return in order and `cmd_ready` rises one cycle after the first pop.
5. **Count wrap.** 256 operations: `op_count` returns to 0x00. The 257th makes it 0x01.
6. **Reset mid-operation.** Assert `rst` during ISSUE with 3 commands queued.
   - Outputs go to reset values asynchronously.
   - After release: `busy=0` and no stale result appears.
